frame_tick_monitor: RTL and testbench
=====================================

# frame_tick_monitor

Receive-side checker for the periodic frame-tick pulse produced by the clock divider. It measures the interval between incoming ticks in `clk` cycles and reports each measured period. It declares lock after a run of in-tolerance periods and flags missing or off-rate ticks. It sits next to any consumer of a frame tick (display timing, frame-rate-driven logic) and gives health and status visibility on that tick.

## Interface
Parameters:
- `CLK_SPEED_HZ`, 100_000_000: native clock frequency.
- `FPS`, 60: nominal tick rate. `EXPECTED = CLK_SPEED_HZ/FPS` (integer, remainder dropped).
- `TOL_CYCLES`, 16: maximum allowed |period − EXPECTED| for a period to count as good.
- `LOCK_COUNT`, 4: consecutive good periods needed to lock (≥1).

Derived width: `W = $clog2(2*EXPECTED+1)`.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `pulse`, in, 1: tick input, synchronous to `clk`, any high width.
- `period`, out, W: last measured interval in cycles.
- `period_valid`, out, 1: one-cycle strobe when `period` updates.
- `locked`, out, 1: level, high while in LOCKED.
- `missed`, out, 1: one-cycle strobe on timeout.
- `err_count`, out, 8: saturating count of bad periods and timeouts.

## Operation
- Edge detect: registered `pulse_d`, reset 0. Edge = `pulse & ~pulse_d`. A held-high pulse counts once. A pulse high at reset release is an edge.
- Interval counter `cnt` (W bits):
  - loads 1 in the cycle after an edge;
  - increments otherwise while the state is not IDLE;
  - holds in IDLE.
  - Edges at cycles t0 and t1 give a captured period of t1−t0.
- Good period: `EXPECTED−TOL_CYCLES ≤ p ≤ EXPECTED+TOL_CYCLES`, with the lower bound clamped at 1.
- State machine:
  - **IDLE** (reset state). Edge → ACQUIRE. No period is reported for this first edge; `good_cnt`=0.
  - **ACQUIRE.**
    - Edge with good period: `good_cnt`+1. If it reaches LOCK_COUNT → LOCKED.
    - Edge with bad period: `good_cnt`=0, `err_count`+1, stay.
  - **LOCKED.**
    - Edge with good period: stay.
    - Edge with bad period: → ACQUIRE, `good_cnt`=0, `err_count`+1.
  - **Timeout** (ACQUIRE or LOCKED): `cnt == 2*EXPECTED` and no edge this cycle. Effects: `missed`=1 for one cycle, → IDLE, `err_count`+1, `good_cnt`=0.
- Edge and timeout in the same cycle: the edge wins. The period is 2*EXPECTED, which is bad, so the normal bad-period path applies and there is no `missed`.
- `err_count` saturates at 255 and only reset clears it.
- Reset mid-operation clears everything immediately; no partial period is reported.
- Reset values: `period`=0, `period_valid`=0, `locked`=0, `missed`=0, `err_count`=0, state IDLE, `cnt`=0.

## Timing
- Edge in cycle N:
  - `period`/`period_valid` are registered and visible in cycle N+1.
  - State change and `err_count` update are also visible at N+1.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_COUNT-th consecutive good period.
- `locked` falls in the same cycle as the `period_valid` of the first bad period, or with `missed`.
- `missed` is asserted in the cycle after `cnt` reaches 2*EXPECTED.
- Minimum supported spacing: an edge every 2 cycles, giving period=2, every period reported.
- All outputs are registered; there is no combinational path from `pulse`.

## Structure
- Package `frame_tick_pkg`:
  - state enum {IDLE, ACQUIRE, LOCKED};
  - helper function for the W computation;
  - `ERR_MAX` = 8'd255.
- Sub-module `tick_interval_counter`: edge detector plus interval counter with the capture and timeout outputs. The top holds the FSM, the tolerance compare, and the counters.

## Test plan
All scenarios use `CLK_SPEED_HZ`=1000, `FPS`=10 (EXPECTED=100, W=8), `TOL_CYCLES`=2, `LOCK_COUNT`=4.
1. 1-cycle pulses every 100 cycles → `period`=100 on each strobe; `locked` rises with the 4th strobe (5th edge); `err_count`=0.
2. While locked, one interval of 103 → `err_count`=1, `locked` drops on that strobe; four further 100s relock it; intervals 98 and 102 never count as errors.
3. While locked, stop pulses → `missed` strobes exactly 200 cycles after the last edge; `locked`=0, `err_count`+1; the next edge reports no period.
4. Pulse held high for 10 cycles, repeating every 100 → single edge each time, `period`=100.
5. Assert `rst_n` low mid-interval while locked → all outputs 0 immediately; after release, one edge gives no `period_valid`.
6. Alternate intervals of 50 and 150 for 300 edges → `err_count` stops at 255; `locked` never asserts.

Source files
------------

// File: rtl/frame_tick_pkg.sv
// Shared types and helpers for the frame-tick monitor.
//   state_e   : monitor state (IDLE / ACQUIRE / LOCKED)
//   ERR_MAX   : saturation value of the error counter
//   cnt_width : interval-counter width able to hold 0 .. 2*expected
package frame_tick_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    localparam logic [7:0] ERR_MAX = 8'd255;

    function automatic int cnt_width(input int expected);
        return $clog2(2 * expected + 1);
    endfunction

endpackage

// File: rtl/tick_interval_counter.sv
// Rising-edge detector and cycle counter measuring the distance between ticks.
//   clk, rst_n : clock, async active-low reset
//   pulse_i    : tick input (any high width)
//   hold_i     : freeze the counter (monitor idle)
//   edge_o     : combinational rising-edge indication for this cycle
//   cnt_o      : cycles since the last edge (equals the period on the next edge)
//   timeout_o  : counter reached 2*EXPECTED with no edge this cycle
module tick_interval_counter #(
    parameter int EXPECTED = 100,
    parameter int W        = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pulse_i,
    input  logic         hold_i,
    output logic         edge_o,
    output logic [W-1:0] cnt_o,
    output logic         timeout_o
);

    localparam logic [W-1:0] TMO = W'(2 * EXPECTED);

    logic         pulse_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // pulse_q resets low so a pulse already high at reset release counts as an edge.
    assign edge_o    = pulse_i & ~pulse_q;
    assign timeout_o = ~hold_i & ~edge_o & (cnt_q == TMO);
    assign cnt_o     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (edge_o) begin
            cnt_d = W'(1);
        end else if (!hold_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_i;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_tick_monitor.sv
// Frame-tick health monitor: measures tick period, declares lock after a run of
// in-tolerance periods, flags missing ticks and counts errors.
//   clk, rst_n   : clock, async active-low reset
//   pulse        : frame tick input
//   period       : last measured interval in clk cycles
//   period_valid : one-cycle strobe when period updates
//   locked       : high while in LOCKED
//   missed       : one-cycle strobe on tick timeout
//   err_count    : saturating count of bad periods and timeouts
//
// state   | meaning
// IDLE    | no reference tick yet; counter frozen
// ACQUIRE | measuring, fewer than LOCK_COUNT consecutive good periods
// LOCKED  | tick is running at the nominal rate
module frame_tick_monitor
    import frame_tick_pkg::*;
#(
    parameter int CLK_SPEED_HZ = 100_000_000,
    parameter int FPS          = 60,
    parameter int TOL_CYCLES   = 16,
    parameter int LOCK_COUNT   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   pulse,
    output logic [cnt_width(CLK_SPEED_HZ/FPS)-1:0] period,
    output logic                                   period_valid,
    output logic                                   locked,
    output logic                                   missed,
    output logic [7:0]                             err_count
);

    localparam int EXPECTED = CLK_SPEED_HZ / FPS;
    localparam int W        = cnt_width(EXPECTED);
    localparam int GOOD_LO  = (EXPECTED - TOL_CYCLES < 1) ? 1 : EXPECTED - TOL_CYCLES;
    localparam int GOOD_HI  = EXPECTED + TOL_CYCLES;
    // good_cnt only ever holds 0 .. LOCK_COUNT-1; the LOCK_COUNT-th good period moves to LOCKED.
    localparam int GW       = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT);

    state_e         state_q, state_d;
    logic [GW-1:0]  good_cnt_q, good_cnt_d;
    logic [W-1:0]   period_q;
    logic           period_valid_q;
    logic           missed_q, missed_d;
    logic [7:0]     err_q;
    logic           err_inc;

    logic           edge_det;
    logic [W-1:0]   cnt;
    logic           timeout;
    int             p_int;
    logic           period_good;

    tick_interval_counter #(
        .EXPECTED (EXPECTED),
        .W        (W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .pulse_i   (pulse),
        .hold_i    (state_q == IDLE),
        .edge_o    (edge_det),
        .cnt_o     (cnt),
        .timeout_o (timeout)
    );

    assign p_int       = int'(cnt);
    assign period_good = (p_int >= GOOD_LO) && (p_int <= GOOD_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An edge takes priority over a coincident timeout (the counter module masks it).
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_inc    = 1'b0;
        missed_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (edge_det) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            ACQUIRE: begin
                if (edge_det) begin
                    if (period_good) begin
                        if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + GW'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                        err_inc    = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = IDLE;
                    good_cnt_d = '0;
                    err_inc    = 1'b1;
                    missed_d   = 1'b1;
                end
            end
            LOCKED: begin
                if (edge_det) begin
                    if (!period_good) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                        err_inc    = 1'b1;
                    end
                end else if (timeout) begin
                    state_d    = IDLE;
                    good_cnt_d = '0;
                    err_inc    = 1'b1;
                    missed_d   = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        locked = (state_q == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            missed_q       <= 1'b0;
            err_q          <= '0;
        end else begin
            good_cnt_q     <= good_cnt_d;
            missed_q       <= missed_d;
            // The first edge out of IDLE has no reference, so it reports nothing.
            period_valid_q <= edge_det && (state_q != IDLE);
            if (edge_det && (state_q != IDLE)) begin
                period_q <= cnt;
            end
            if (err_inc && (err_q != ERR_MAX)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign missed       = missed_q;
    assign err_count    = err_q;

endmodule

// File: tb/tb_frame_tick_monitor.sv
module tb_frame_tick_monitor;

    localparam int CLK_HZ = 1000;
    localparam int FPS_P  = 10;
    localparam int TOL    = 2;
    localparam int LOCKN  = 4;
    localparam int EXP    = CLK_HZ / FPS_P;
    localparam int LO     = (EXP - TOL < 1) ? 1 : EXP - TOL;
    localparam int HI     = EXP + TOL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       missed;
    logic [7:0] err_count;

    frame_tick_monitor #(
        .CLK_SPEED_HZ (CLK_HZ),
        .FPS          (FPS_P),
        .TOL_CYCLES   (TOL),
        .LOCK_COUNT   (LOCKN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pulse        (pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .missed       (missed),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model: absolute edge times, run length of good periods.
    int   t;
    bit   have_ref;
    int   last_t;
    int   run;
    int   m_err;
    int   m_period;
    bit   m_pv;
    bit   m_missed;
    bit   prev_pulse;
    int   p;

    int   pv_count;
    int   missed_count;
    int   last_pv_cyc;
    int   missed_cyc;
    bit   in_sc6;
    bit   lock_seen;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                t = 0; have_ref = 0; last_t = 0; run = 0; m_err = 0;
                m_period = 0; m_pv = 0; m_missed = 0; prev_pulse = 0;
            end else begin
                t++;
                m_pv = 0;
                m_missed = 0;
                if (pulse && !prev_pulse) begin
                    if (have_ref) begin
                        p = t - last_t;
                        m_pv = 1;
                        m_period = p;
                        if (p >= LO && p <= HI) begin
                            run++;
                        end else begin
                            run = 0;
                            if (m_err < 255) m_err++;
                        end
                    end else begin
                        run = 0;
                    end
                    have_ref = 1;
                    last_t = t;
                end else if (have_ref && (t - last_t) == 2 * EXP) begin
                    m_missed = 1;
                    have_ref = 0;
                    run = 0;
                    if (m_err < 255) m_err++;
                end
                prev_pulse = pulse;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                chk("period", int'(period), m_period);
                chk("period_valid", int'(period_valid), int'(m_pv));
                chk("locked", int'(locked), (run >= LOCKN) ? 1 : 0);
                chk("missed", int'(missed), int'(m_missed));
                chk("err_count", int'(err_count), m_err);
                if (period_valid) begin pv_count++; last_pv_cyc = cyc; end
                if (missed) begin missed_count++; missed_cyc = cyc; end
                if (in_sc6 && locked) lock_seen = 1;
            end
        end
    end

    task automatic tick(input int width, input int interval);
        pulse = 1'b1;
        repeat (width) @(negedge clk);
        pulse = 1'b0;
        repeat (interval - width) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_missed", int'(missed), 0);
        chk("rst_err", int'(err_count), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    int n0;
    int r;
    int iv;
    int wd;

    initial begin
        rst_n = 1'b0;
        pulse = 1'b0;
        pv_count = 0; missed_count = 0; last_pv_cyc = 0; missed_cyc = 0;
        in_sc6 = 0; lock_seen = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_period", int'(period), 0);
        chk("init_locked", int'(locked), 0);
        chk("init_err", int'(err_count), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: nominal ticks, lock on the 4th period (5th edge)
        repeat (4) tick(1, 100);
        #1 chk("sc1_not_yet_locked", int'(locked), 0);
        tick(1, 100);
        #1 chk("sc1_locked", int'(locked), 1);
        chk("sc1_period", int'(period), 100);
        chk("sc1_err", int'(err_count), 0);
        chk("sc1_pv_count", pv_count, 4);

        // 2: one 103 interval, relock, 98/102 stay good
        tick(1, 103);
        tick(1, 100);
        #1 chk("sc2_err", int'(err_count), 1);
        chk("sc2_unlocked", int'(locked), 0);
        chk("sc2_period", int'(period), 103);
        chk("model_err_sc2", m_err, 1);
        repeat (4) tick(1, 100);
        #1 chk("sc2_relocked", int'(locked), 1);
        tick(1, 98);
        tick(1, 102);
        tick(1, 100);
        #1 chk("sc2_tol_err", int'(err_count), 1);
        chk("sc2_tol_locked", int'(locked), 1);
        chk("sc2_tol_period", int'(period), 102);

        // 3: stop ticks -> missed 200 cycles after the last edge
        repeat (250) @(negedge clk);
        #1 chk("sc3_missed_count", missed_count, 1);
        chk("sc3_missed_delay", missed_cyc - last_pv_cyc, 200);
        chk("sc3_locked", int'(locked), 0);
        chk("sc3_err", int'(err_count), 2);
        n0 = pv_count;
        tick(1, 100);
        #1 chk("sc3_no_period_after_idle", pv_count, n0);

        // 4: wide pulses count once each
        repeat (5) tick(10, 100);
        #1 chk("sc4_period", int'(period), 100);
        chk("sc4_pv_count", pv_count, n0 + 5);
        chk("sc4_locked", int'(locked), 1);
        chk("sc4_err", int'(err_count), 2);

        // 5: reset mid-interval while locked
        repeat (30) @(negedge clk);
        do_reset();
        n0 = pv_count;
        tick(1, 100);
        #1 chk("sc5_no_period", pv_count, n0);
        chk("sc5_err", int'(err_count), 0);

        // 6: alternating 50/150 saturates the error counter
        in_sc6 = 1;
        repeat (150) begin
            tick(1, 50);
            tick(1, 150);
        end
        in_sc6 = 0;
        #1 chk("sc6_err_sat", int'(err_count), 255);
        chk("model_err_sc6", m_err, 255);
        chk("sc6_never_locked", int'(lock_seen), 0);

        // Random intervals around nominal, minimum spacing, timeouts, exact-2E edges
        do_reset();
        repeat (300) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4, 5: iv = $urandom_range(97, 103);
                6:                iv = $urandom_range(2, 5);
                7:                iv = $urandom_range(195, 210);
                8:                iv = 200;
                default:          iv = $urandom_range(50, 150);
            endcase
            wd = $urandom_range(1, (iv - 1 < 8) ? iv - 1 : 8);
            tick(wd, iv);
        end
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
